// File: rtl/ddma_tcd_ctrl.sv
// CPU-side command/status controller for the distributed DMA: descriptor registers,
// send/receive command sequencers and IRQ aggregation. Optional watchdog: DDMA_TCD_TIMEOUT_EN.
module ddma_tcd_ctrl #(
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [3:0]                  cpu_addr_in,
   input  logic                        cpu_wr_in,
   input  logic                        cpu_rd_in,
   input  logic [MEMORY_BUS_WIDTH-1:0] cpu_data_in,
   output logic [MEMORY_BUS_WIDTH-1:0] cpu_data_out,
   output logic                        cpu_ready_out,
   output logic [MEMORY_BUS_WIDTH-1:0] send_addr_out,
   output logic [MEMORY_BUS_WIDTH-1:0] send_size_out,
   output logic [MEMORY_BUS_WIDTH-1:0] send_dest_out,
   output logic                        send_cmd_out,
   output logic [MEMORY_BUS_WIDTH-1:0] recv_addr_out,
   output logic                        recv_cmd_out,
   input  logic [MEMORY_BUS_WIDTH-1:0] recv_size_in,
   input  logic [7:0]                  state_send_in,
   input  logic [7:0]                  state_recv_in,
   input  logic                        irq_send_in,
   input  logic                        irq_recv_size_in,
   input  logic                        irq_recv_hshk_in,
   output logic                        irq_out
);

   localparam int W = MEMORY_BUS_WIDTH;
`ifdef DDMA_TCD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } chan_state_t;

   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] send_addr_reg;
   logic [W-1:0] send_size_reg;
   logic [W-1:0] send_dest_reg;
   logic [W-1:0] recv_addr_reg;
   logic [W-1:0] recv_size_reg;
   logic [4:0]   irq_mask_reg;
   logic [4:0]   irq_pend_reg;
   logic [4:0]   irq_pend_next;
   logic [4:0]   pend_set;
   logic [4:0]   pend_clr;
   logic         irq_out_reg;
   logic         cpu_ready_reg;
   logic [W-1:0] cpu_data_reg;
   logic [W-1:0] rd_data;

   // Channel vectors: index 0 = send, index 1 = receive.
   logic [1:0]   start_req;
   logic [1:0]   chan_start;
   logic [1:0]   chan_idle;
   logic [1:0]   chan_cmd;
   logic [1:0]   chan_active;
   logic [1:0]   chan_done;
   logic [1:0]   chan_to;
   logic         desc_err;
   logic         cmd_err;

   // A simultaneous read and write is treated as a write that returns 0.
   assign wr_en = cpu_wr_in;
   assign rd_en = cpu_rd_in & ~cpu_wr_in;

   assign start_req   = (wr_en && cpu_addr_in == 4'd4) ? cpu_data_in[1:0] : 2'b00;
   assign chan_start  = start_req & chan_idle;
   assign chan_active = {(state_recv_in != 8'h00), (state_send_in != 8'h00)};
   assign chan_done   = {irq_recv_size_in, irq_send_in};
   assign desc_err    = wr_en && ((cpu_addr_in <= 4'd2 && !chan_idle[0]) ||
                                  (cpu_addr_in == 4'd3 && !chan_idle[1]));
   assign cmd_err     = (|(start_req & ~chan_idle)) | desc_err;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         chan_state_t state_reg;
         chan_state_t state_next;
         logic        timeout;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) state_reg <= ST_IDLE;
            else        state_reg <= state_next;
         end

         // A completion event during ISSUE finishes the command without passing BUSY.
         always_comb begin
            state_next = state_reg;
            case (state_reg)
               ST_IDLE:  if (chan_start[gi]) state_next = ST_ISSUE;
               ST_ISSUE: begin
                  if (chan_done[gi] || timeout) state_next = ST_IDLE;
                  else if (chan_active[gi])     state_next = ST_BUSY;
               end
               ST_BUSY:  if (chan_done[gi] || timeout) state_next = ST_IDLE;
               default:  state_next = ST_IDLE;
            endcase
         end

`ifdef DDMA_TCD_TIMEOUT_EN
         logic [CW-1:0] cnt_reg;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset)                  cnt_reg <= '0;
            else if (chan_start[gi])     cnt_reg <= '0;
            else if (state_reg != ST_IDLE) cnt_reg <= cnt_reg + 1'b1;
         end

         assign timeout = (state_reg != ST_IDLE) && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
         assign timeout = 1'b0;
`endif

         assign chan_idle[gi] = (state_reg == ST_IDLE);
         assign chan_cmd[gi]  = (state_reg == ST_ISSUE);
         assign chan_to[gi]   = timeout;
      end
   endgenerate

   assign pend_set = {(|chan_to), cmd_err, irq_recv_hshk_in, irq_recv_size_in, irq_send_in};
   assign pend_clr = (wr_en && cpu_addr_in == 4'd7) ? cpu_data_in[4:0] : 5'd0;
   // Hardware set overrides a software clear landing in the same cycle.
   assign irq_pend_next = (irq_pend_reg & ~pend_clr) | pend_set;

   always_comb begin
      rd_data = '0;
      case (cpu_addr_in)
         4'd0: rd_data = send_addr_reg;
         4'd1: rd_data = send_size_reg;
         4'd2: rd_data = send_dest_reg;
         4'd3: rd_data = recv_addr_reg;
         4'd5: rd_data = W'({state_send_in, state_recv_in, 6'd0, ~chan_idle[1], ~chan_idle[0]});
         4'd6: rd_data = recv_size_reg;
         4'd7: rd_data = W'(irq_pend_reg);
         4'd8: rd_data = W'(irq_mask_reg);
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         send_addr_reg <= '0;
         send_size_reg <= '0;
         send_dest_reg <= '0;
         recv_addr_reg <= '0;
         recv_size_reg <= '0;
         irq_mask_reg  <= '0;
         irq_pend_reg  <= '0;
         irq_out_reg   <= 1'b0;
         cpu_ready_reg <= 1'b0;
         cpu_data_reg  <= '0;
      end else begin
         if (wr_en && chan_idle[0] && cpu_addr_in == 4'd0) send_addr_reg <= cpu_data_in;
         if (wr_en && chan_idle[0] && cpu_addr_in == 4'd1) send_size_reg <= cpu_data_in;
         if (wr_en && chan_idle[0] && cpu_addr_in == 4'd2) send_dest_reg <= cpu_data_in;
         if (wr_en && chan_idle[1] && cpu_addr_in == 4'd3) recv_addr_reg <= cpu_data_in;
         if (wr_en && cpu_addr_in == 4'd8)                 irq_mask_reg  <= cpu_data_in[4:0];
         // Size is captured on every size event, including stray ones while idle.
         if (irq_recv_size_in)                             recv_size_reg <= recv_size_in;
         irq_pend_reg  <= irq_pend_next;
         irq_out_reg   <= |(irq_pend_reg & irq_mask_reg);
         cpu_ready_reg <= cpu_wr_in | cpu_rd_in;
         cpu_data_reg  <= rd_en ? rd_data : '0;
      end
   end

   assign send_addr_out = send_addr_reg;
   assign send_size_out = send_size_reg;
   assign send_dest_out = send_dest_reg;
   assign recv_addr_out = recv_addr_reg;
   assign send_cmd_out  = chan_cmd[0];
   assign recv_cmd_out  = chan_cmd[1];
   assign irq_out       = irq_out_reg;
   assign cpu_ready_out = cpu_ready_reg;
   assign cpu_data_out  = cpu_data_reg;

endmodule

// File: tb/tb_ddma_tcd_ctrl.sv
// Scoreboard bench for ddma_tcd_ctrl: bus responses checked by a monitor, sideband by direct checks.
module tb_ddma_tcd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cpu_addr;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_data_out;
   logic        cpu_ready_out;
   logic [31:0] send_addr_out;
   logic [31:0] send_size_out;
   logic [31:0] send_dest_out;
   logic        send_cmd_out;
   logic [31:0] recv_addr_out;
   logic        recv_cmd_out;
   logic [31:0] recv_size_in;
   logic [7:0]  state_send_in;
   logic [7:0]  state_recv_in;
   logic        irq_send_in;
   logic        irq_recv_size_in;
   logic        irq_recv_hshk_in;
   logic        irq_out;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cnt;

   always #5 clk = ~clk;

   ddma_tcd_ctrl #(.MEMORY_BUS_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clock            (clk),
      .reset            (rst_n),
      .cpu_addr_in      (cpu_addr),
      .cpu_wr_in        (cpu_wr),
      .cpu_rd_in        (cpu_rd),
      .cpu_data_in      (cpu_wdata),
      .cpu_data_out     (cpu_data_out),
      .cpu_ready_out    (cpu_ready_out),
      .send_addr_out    (send_addr_out),
      .send_size_out    (send_size_out),
      .send_dest_out    (send_dest_out),
      .send_cmd_out     (send_cmd_out),
      .recv_addr_out    (recv_addr_out),
      .recv_cmd_out     (recv_cmd_out),
      .recv_size_in     (recv_size_in),
      .state_send_in    (state_send_in),
      .state_recv_in    (state_recv_in),
      .irq_send_in      (irq_send_in),
      .irq_recv_size_in (irq_recv_size_in),
      .irq_recv_hshk_in (irq_recv_hshk_in),
      .irq_out          (irq_out)
   );

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && cpu_ready_out) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ready: data=%h with no access outstanding", cpu_data_out);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (cpu_data_out !== e.val) begin
               n_err++;
               $display("FAIL %s: got %h expected %h", e.name, cpu_data_out, e.val);
            end else begin
               $display("bus %s: data=%h", e.name, cpu_data_out);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("chk %s: %h", name, act);
      end
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input string name);
      exp_t e;
      @(negedge clk);
      cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
      e.name = name; e.val = 32'h0;
      sb_q.push_back(e);
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      cpu_addr = a; cpu_rd = 1'b1;
      e.name = name; e.val = exp;
      sb_q.push_back(e);
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      cpu_addr = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = '0;
      recv_size_in = '0; state_send_in = '0; state_recv_in = '0;
      irq_send_in = 1'b0; irq_recv_size_in = 1'b0; irq_recv_hshk_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      check("rst_send_cmd", {31'd0, send_cmd_out}, 32'd0);
      check("rst_irq_out", {31'd0, irq_out}, 32'd0);
      check("rst_send_addr", send_addr_out, 32'd0);
      bus_rd(4'd5, 32'h0, "rst_status");
      bus_rd(4'd7, 32'h0, "rst_pend");
      bus_rd(4'd8, 32'h0, "rst_mask");

      // Read and write together: write wins, read data 0.
      @(negedge clk);
      cpu_addr = 4'd0; cpu_wdata = 32'h55; cpu_wr = 1'b1; cpu_rd = 1'b1;
      e.name = "rdwr_data"; e.val = 32'h0;
      sb_q.push_back(e);
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      check("rdwr_write", send_addr_out, 32'h55);

      // Send descriptor and command
      bus_wr(4'd0, 32'h100, "wr_send_addr");
      bus_wr(4'd1, 32'h40, "wr_send_size");
      bus_wr(4'd2, 32'h3, "wr_send_dest");
      check("send_addr_out", send_addr_out, 32'h100);
      check("send_size_out", send_size_out, 32'h40);
      check("send_dest_out", send_dest_out, 32'h3);
      bus_rd(4'd1, 32'h40, "rd_send_size");
      bus_rd(4'd4, 32'h0, "rd_cmd_wo");
      bus_rd(4'd9, 32'h0, "rd_unmapped");

      bus_wr(4'd4, 32'h1, "wr_cmd_send");
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (send_cmd_out) cnt++;
         if (k == 2) state_send_in = 8'h01;
         @(negedge clk);
      end
      check("send_cmd_cycles", cnt, 32'd3);
      bus_rd(4'd5, 32'h0001_0001, "status_send_busy");

      @(negedge clk);
      irq_send_in = 1'b1; state_send_in = 8'h00;
      @(negedge clk);
      irq_send_in = 1'b0;
      bus_rd(4'd7, 32'h1, "pend_send_done");
      bus_rd(4'd5, 32'h0, "status_send_idle");

      bus_wr(4'd8, 32'h1, "wr_mask");
      check("irq_latency", {31'd0, irq_out}, 32'd0);
      @(negedge clk);
      check("irq_asserted", {31'd0, irq_out}, 32'd1);
      bus_wr(4'd7, 32'h1, "w1c_send");
      @(negedge clk);
      check("irq_cleared", {31'd0, irq_out}, 32'd0);
      bus_rd(4'd7, 32'h0, "pend_after_w1c");

      // Receive
      bus_wr(4'd3, 32'h200, "wr_recv_addr");
      check("recv_addr_out", recv_addr_out, 32'h200);
      bus_wr(4'd4, 32'h2, "wr_cmd_recv");
      check("recv_cmd_issue", {31'd0, recv_cmd_out}, 32'd1);
      state_recv_in = 8'h01;
      @(negedge clk);
      check("recv_cmd_busy", {31'd0, recv_cmd_out}, 32'd0);
      bus_rd(4'd5, 32'h0000_0102, "status_recv_busy");
      @(negedge clk);
      irq_recv_size_in = 1'b1; recv_size_in = 32'h2C; state_recv_in = 8'h00;
      @(negedge clk);
      irq_recv_size_in = 1'b0; recv_size_in = 32'h77;
      bus_rd(4'd6, 32'h2C, "recv_size");
      bus_rd(4'd7, 32'h2, "pend_recv");
      bus_rd(4'd5, 32'h0, "status_recv_idle");
      bus_wr(4'd7, 32'h2, "w1c_recv");

      // Commands and descriptor writes while send is busy
      bus_wr(4'd4, 32'h1, "wr_cmd_send2");
      state_send_in = 8'h01;
      @(negedge clk);
      bus_wr(4'd4, 32'h1, "wr_cmd_busy");
      check("no_retrigger", {31'd0, send_cmd_out}, 32'd0);
      bus_wr(4'd1, 32'h99, "wr_size_busy");
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (send_cmd_out) cnt++;
         @(negedge clk);
      end
      check("no_second_cmd", cnt, 32'd0);
      check("size_out_kept", send_size_out, 32'h40);
      bus_rd(4'd1, 32'h40, "size_kept");
      bus_rd(4'd7, 32'h8, "pend_cmd_err");
      bus_rd(4'd5, 32'h0001_0001, "status_busy2");

      // Handshake set and W1C on the same cycle
      @(negedge clk);
      cpu_addr = 4'd7; cpu_wdata = 32'h4; cpu_wr = 1'b1; irq_recv_hshk_in = 1'b1;
      e.name = "w1c_hshk"; e.val = 32'h0;
      sb_q.push_back(e);
      @(negedge clk);
      cpu_wr = 1'b0; irq_recv_hshk_in = 1'b0;
      bus_rd(4'd7, 32'hC, "pend_hshk_wins");

      // Asynchronous reset with send still busy
      bus_wr(4'd8, 32'h1F, "wr_mask_all");
      @(negedge clk);
      check("irq_before_rst", {31'd0, irq_out}, 32'd1);
      state_send_in = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_irq", {31'd0, irq_out}, 32'd0);
      check("rst_async_cmd", {31'd0, send_cmd_out}, 32'd0);
      check("rst_async_size", send_size_out, 32'd0);
      #9 rst_n = 1'b1;
      bus_rd(4'd5, 32'h0, "status_after_rst");
      bus_rd(4'd7, 32'h0, "pend_after_rst");
      bus_rd(4'd8, 32'h0, "mask_after_rst");

      // DDMA never acknowledges the send command
      bus_wr(4'd4, 32'h1, "wr_cmd_stall");
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (send_cmd_out) cnt++;
         @(negedge clk);
      end
`ifdef DDMA_TCD_TIMEOUT_EN
      check("stall_cmd_cycles", cnt, 32'd16);
      bus_rd(4'd7, 32'h10, "pend_timeout");
      bus_rd(4'd5, 32'h0, "status_timeout");
`else
      check("stall_cmd_cycles", cnt, 32'd40);
      bus_rd(4'd7, 32'h0, "pend_no_timeout");
      bus_rd(4'd5, 32'h1, "status_stalled");
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ddma_tcd_ctrl.md
Name: ddma_tcd_ctrl

Overview:
CPU-facing controller that drives the command side of the distributed DMA (DDMA): memory-mapped registers for send/receive descriptors, per-channel command sequencers, and IRQ aggregation. It sits between the core's peripheral bus and the DDMA command/status signals. It issues send and receive commands, waits for DMA acceptance and completion, latches received packet sizes, and raises one maskable interrupt line to the core.

Parameters:
MEMORY_BUS_WIDTH, 32, width of address/size/dest/data words
TIMEOUT_CYCLES, 1024, watchdog limit per command; used only with DDMA_TCD_TIMEOUT_EN

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
cpu_addr_in  input  4  register word offset
cpu_wr_in  input  1  write strobe, one cycle
cpu_rd_in  input  1  read strobe, one cycle
cpu_data_in  input  MEMORY_BUS_WIDTH  write data
cpu_data_out  output  MEMORY_BUS_WIDTH  read data, valid with cpu_ready_out
cpu_ready_out  output  1  access acknowledge
send_addr_out / send_size_out / send_dest_out  output  MEMORY_BUS_WIDTH each  send descriptor to DDMA
send_cmd_out  output  1  send command
recv_addr_out  output  MEMORY_BUS_WIDTH  receive buffer address to DDMA
recv_cmd_out  output  1  receive command
recv_size_in  input  MEMORY_BUS_WIDTH  received packet size from DDMA
state_send_in / state_recv_in  input  8 each  DDMA channel state; 8'h00 = idle
irq_send_in / irq_recv_size_in / irq_recv_hshk_in  input  1 each  DDMA event pulses
irq_out  output  1  interrupt to core

Behaviour:
- Reset (async, reset=0): all outputs and registers 0; both FSMs IDLE; irq_out=0.
- Register map (word offsets): 0 SEND_ADDR rw; 1 SEND_SIZE rw; 2 SEND_DEST rw; 3 RECV_ADDR rw; 4 CMD wo (bit0 start send, bit1 start recv); 5 STATUS ro {[23:16] state_send_in, [15:8] state_recv_in, bit1 recv busy, bit0 send busy}; 6 RECV_SIZE ro; 7 IRQ_PEND w1c; 8 IRQ_MASK rw (reset 0). Other offsets: reads 0, writes ignored.
- Bus: cpu_ready_out pulses exactly 1 cycle after any rd/wr strobe; cpu_data_out registered, valid in that cycle, 0 otherwise. rd and wr in same cycle: write wins, read data 0.
- Descriptor outputs are the register values combinationally (no extra latency).
- IRQ_PEND bits: 0 send done, 1 recv size ready, 2 recv handshake, 3 command error, 4 timeout.
- Send FSM: IDLE -> ISSUE on CMD bit0 write. ISSUE: send_cmd_out=1, held until state_send_in != 0, then BUSY next cycle (send_cmd_out=0). BUSY -> IDLE on irq_send_in; set pend bit0. irq_send_in in ISSUE also completes (-> IDLE, bit0).
- Recv FSM: identical with recv_cmd_out/state_recv_in; BUSY ends on irq_recv_size_in; recv_size_in latched into RECV_SIZE same edge; pend bit1.
- irq_recv_hshk_in sets pend bit2 in any state.
- Start while channel not IDLE: ignored, pend bit3 set. Write to SEND_* while send not IDLE, or RECV_ADDR while recv not IDLE: ignored, bit3 set. Both starts in one write: both channels start.
- Event in IDLE (stray irq_send_in / irq_recv_size_in): pend bit set, no FSM change; RECV_SIZE still latched.
- W1C and hardware set of same bit same cycle: set wins.
- irq_out registered: |(IRQ_PEND & IRQ_MASK[4:0]), 1-cycle latency.

Optional Feature:
DDMA_TCD_TIMEOUT_EN: per-channel counter cleared on entering ISSUE, incremented in ISSUE/BUSY; at TIMEOUT_CYCLES the channel drops cmd, returns IDLE, sets pend bit4. Without macro: no counters, channels wait indefinitely, bit4 reads 0.

Test Plan:
- Reset mid-BUSY (send active, reset=0 for 1 cycle) -> send_cmd_out=0, STATUS=0, IRQ_PEND=0, irq_out=0 immediately.
- Write SEND_ADDR=0x100, SIZE=0x40, DEST=0x3, CMD=1; DDMA raises state_send_in=1 after 3 cycles -> send_cmd_out high exactly 3 cycles; irq_send_in pulse -> IRQ_PEND=0x1; MASK=0x1 -> irq_out=1 one cycle later; W1C 0x1 -> irq_out=0.
- Arm recv RECV_ADDR=0x200, CMD=2; irq_recv_size_in with recv_size_in=0x2C -> RECV_SIZE reads 0x2C, pend bit1, recv busy=0.
- CMD=1 while send BUSY, and SEND_SIZE write while BUSY -> SEND_SIZE unchanged, pend bit3, no second send_cmd_out.
- irq_recv_hshk_in same cycle as W1C of bit2 -> bit2 remains 1.
- With DDMA_TCD_TIMEOUT_EN, TIMEOUT_CYCLES=16, state_send_in held 0 -> after 16 cycles send_cmd_out=0, pend=0x10; without macro cmd stays high.
